// File: rtl/mux_rr_arbiter16.sv
// Round-robin arbiter sharing one 16-bit output register among WAYS
// valid/ready requesters; winner's word selected by mux_n_way16.

module mux_n_way16 #(
  parameter  int WAYS      = 4,
  localparam int SEL_WIDTH = $clog2(WAYS)
) (
  input  logic [15:0]          d [WAYS],
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [15:0]          y
);

  assign y = d[sel];

endmodule

module mux_rr_arbiter16 #(
  parameter  int WAYS      = 4,
  localparam int SEL_WIDTH = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WAYS-1:0]      req_valid,
  input  logic [15:0]          req_data [WAYS],
  output logic [WAYS-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic [SEL_WIDTH-1:0] out_src
);

  logic [SEL_WIDTH-1:0] last;
  logic [SEL_WIDTH-1:0] win;
  logic [SEL_WIDTH-1:0] idx;
  logic                 found;
  logic                 slot_free;
  logic                 xfer;
  logic [15:0]          mux_y;

  // Walk from farthest to nearest so the
  // closest index after last wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = WAYS; k >= 1; k--) begin
      idx = last + SEL_WIDTH'(k);
      if (req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign xfer      = rst_n && found && slot_free;

  always_comb begin
    req_ready = '0;
    if (xfer)
      req_ready[win] = 1'b1;
  end

  mux_n_way16 #(
    .WAYS (WAYS)
  ) u_mux (
    .d   (req_data),
    .sel (win),
    .y   (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_src   <= '0;
      last      <= SEL_WIDTH'(WAYS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= win;
      last      <= win;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter16.sv
// Self-checking bench: WAYS=4 and WAYS=8 arbiters against
// a round-robin reference model plus directed literal checks.

module tb_mux_rr_arbiter16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  v4 = '0;
  logic [15:0] d4 [4];
  logic [3:0]  rdy4;
  logic        ov4;
  logic        ordy4 = 1'b0;
  logic [15:0] od4;
  logic [1:0]  src4;

  logic [7:0]  v8 = '0;
  logic [15:0] d8 [8];
  logic [7:0]  rdy8;
  logic        ov8;
  logic        ordy8 = 1'b0;
  logic [15:0] od8;
  logic [2:0]  src8;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter16 #(.WAYS(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v4),
    .req_data  (d4),
    .req_ready (rdy4),
    .out_valid (ov4),
    .out_ready (ordy4),
    .out_data  (od4),
    .out_src   (src4)
  );

  mux_rr_arbiter16 #(.WAYS(8)) u8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v8),
    .req_data  (d8),
    .req_ready (rdy8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out_data  (od8),
    .out_src   (src8)
  );

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference: first valid index scanning last+1.. mod n
  function automatic int winner(logic [7:0] v, int last,
                                int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  int          mlast [2];
  logic        mval  [2];
  logic [15:0] mdata [2];
  int          msrc  [2];

  function automatic logic [7:0] vin(int u);
    return (u == 1) ? v8 : {4'b0, v4};
  endfunction

  function automatic logic ordin(int u);
    return (u == 1) ? ordy8 : ordy4;
  endfunction

  function automatic logic [15:0] din(int u, int w);
    return (u == 1) ? d8[w % 8] : d4[w % 4];
  endfunction

  function automatic logic [7:0] exp_ready(int u);
    int n, w;
    n = (u == 1) ? 8 : 4;
    w = winner(vin(u), mlast[u], n);
    if (!rst_n || w < 0) return '0;
    if (mval[u] && !ordin(u)) return '0;
    return 8'(1) << w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mval[u]  <= 1'b0;
        mdata[u] <= '0;
        msrc[u]  <= 0;
      end
      mlast[0] <= 3;
      mlast[1] <= 7;
    end else begin
      for (int u = 0; u < 2; u++) begin
        logic [7:0] r;
        int w;
        r = exp_ready(u);
        w = winner(vin(u), mlast[u], u == 1 ? 8 : 4);
        if (r != 0) begin
          mval[u]  <= 1'b1;
          mdata[u] <= din(u, w);
          msrc[u]  <= w;
          mlast[u] <= w;
        end else if (mval[u] && ordin(u)) begin
          mval[u] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m4_ready", {28'b0, rdy4}, {24'b0, exp_ready(0)});
    chk("m4_valid", {31'b0, ov4}, {31'b0, mval[0]});
    chk("m4_data", {16'b0, od4}, {16'b0, mdata[0]});
    chk("m4_src", {30'b0, src4}, 32'(msrc[0]));
    chk("m8_ready", {24'b0, rdy8}, {24'b0, exp_ready(1)});
    chk("m8_valid", {31'b0, ov8}, {31'b0, mval[1]});
    chk("m8_data", {16'b0, od8}, {16'b0, mdata[1]});
    chk("m8_src", {29'b0, src8}, 32'(msrc[1]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d4[i] = '0;
    for (int i = 0; i < 8; i++) d8[i] = '0;
    cyc();
    cyc();
    smp();
    chk("rst_valid", {31'b0, ov4}, 32'd0);
    chk("rst_ready", {28'b0, rdy4}, 32'd0);
    chk("rst_data", {16'b0, od4}, 32'd0);
    cyc();
    rst_n = 1'b1;

    // single requester 2
    v4 = 4'b0100;
    d4[2] = 16'h1113;
    ordy4 = 1'b1;
    smp();
    chk("t1_ready", {28'b0, rdy4}, 32'b0100);
    cyc();
    v4 = '0;
    smp();
    chk("t1_valid", {31'b0, ov4}, 32'd1);
    chk("t1_data", {16'b0, od4}, 32'h1113);
    chk("t1_src", {30'b0, src4}, 32'd2);
    cyc();
    smp();
    chk("drain_valid", {31'b0, ov4}, 32'd0);
    chk("drain_data", {16'b0, od4}, 32'h1113);
    chk("drain_ready", {28'b0, rdy4}, 32'd0);

    // full rotation
    do_reset();
    for (int i = 0; i < 4; i++) d4[i] = 16'h1111 + 16'(i);
    v4 = 4'hf;
    ordy4 = 1'b1;
    smp();
    chk("rot_first", {28'b0, rdy4}, 32'b0001);
    for (int k = 0; k < 8; k++) begin
      cyc();
      smp();
      chk("rot_valid", {31'b0, ov4}, 32'd1);
      chk("rot_src", {30'b0, src4}, 32'(k % 4));
      chk("rot_data", {16'b0, od4}, 32'h1111 + 32'(k % 4));
    end

    // backpressure holding index 0's word
    cyc();
    ordy4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("bp_ready", {28'b0, rdy4}, 32'd0);
      chk("bp_data", {16'b0, od4}, 32'h1111);
      chk("bp_src", {30'b0, src4}, 32'd0);
      chk("bp_valid", {31'b0, ov4}, 32'd1);
      cyc();
    end
    ordy4 = 1'b1;
    smp();
    chk("bp_release", {28'b0, rdy4}, 32'b0010);
    cyc();
    smp();
    chk("bp_next_src", {30'b0, src4}, 32'd1);
    chk("bp_next_data", {16'b0, od4}, 32'h1112);

    // async reset with a stalled word
    ordy4 = 1'b0;
    cyc();
    smp();
    chk("ar_pre_valid", {31'b0, ov4}, 32'd1);
    #1;
    rst_n = 1'b0;
    ordy4 = 1'b1;
    #1;
    chk("ar_valid", {31'b0, ov4}, 32'd0);
    chk("ar_ready", {28'b0, rdy4}, 32'd0);
    cyc();
    rst_n = 1'b1;
    smp();
    chk("ar_first", {28'b0, rdy4}, 32'b0001);
    cyc();
    smp();
    chk("ar_src", {30'b0, src4}, 32'd0);
    v4 = '0;

    // WAYS=8 wrap between 7 and 0
    do_reset();
    d8[0] = 16'ha000;
    d8[7] = 16'ha007;
    v8 = 8'h81;
    ordy8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      chk("wrap_src", {29'b0, src8}, (k % 2 == 0) ? 32'd0 : 32'd7);
      chk("wrap_data", {16'b0, od8},
          (k % 2 == 0) ? 32'ha000 : 32'ha007);
    end
    v8 = '0;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
